// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit that owns the MIPS HI/LO register pair.
// Radix-2 shift-add multiply and restoring divide are run on magnitudes, and a single FIX cycle applies the signs.
module muldiv_unit #(
  parameter int WIDTH = 32,                 // even, >= 4
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 div_q, div_d;
  logic                 neg_q, neg_d;     // negate product / quotient
  logic                 rneg_q, rneg_d;   // negate remainder
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic                 done_q, done_d;

  logic                 sa, sb;
  logic [WIDTH:0]       sum, rsh;
  logic                 qbit;
  logic [2*WIDTH-1:0]   prod;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      div_q   <= 1'b0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      acc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      acc_q   <= acc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    acc_d   = acc_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    sa      = ~op[0] & a[WIDTH-1];
    sb      = ~op[0] & b[WIDTH-1];
    sum     = '0;
    rsh     = '0;
    qbit    = 1'b0;
    prod    = '0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (!flush) begin
            state_d = S_RUN;
            div_d   = op[1];
            neg_d   = sa ^ sb;
            rneg_d  = sa;
            a_d     = sa ? -a : a;
            b_d     = sb ? -b : b;
            acc_d   = '0;
            cnt_d   = CNT_W'(WIDTH);
          end
        end else begin
          if (mthi) hi_d = wdata;
          if (mtlo) lo_d = wdata;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (!div_q) begin
          // Add the multiplicand into the top half, then shift the whole accumulator right.
          sum   = b_q[0] ? ({1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, a_q})
                         : {1'b0, acc_q[2*WIDTH-1:WIDTH]};
          acc_d = {sum, acc_q[WIDTH-1:1]};
          b_d   = b_q >> 1;
        end else begin
          // The partial remainder is kept in the low half of acc, and quotient bits shift into a_q.
          rsh  = {acc_q[WIDTH-1:0], a_q[WIDTH-1]};
          qbit = (rsh >= {1'b0, b_q});
          if (qbit) rsh = rsh - {1'b0, b_q};
          acc_d = {{WIDTH{1'b0}}, rsh[WIDTH-1:0]};
          a_d   = {a_q[WIDTH-2:0], qbit};
        end
        if (cnt_q == CNT_W'(1)) state_d = S_FIX;
      end
      S_FIX: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        if (!div_q) begin
          prod = neg_q ? -acc_q : acc_q;
          hi_d = prod[2*WIDTH-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end else begin
          lo_d = neg_q  ? -a_q : a_q;
          hi_d = rneg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (flush && state_q != S_IDLE) begin
      state_d = S_IDLE;
      done_d  = 1'b0;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised multi-cycle multiply/divide unit that owns the HI/LO register pair for the pipelined MIPS datapath. It replaces the always-written HI/LO registers with a block that computes the results itself. It sits beside the EX-stage ALU, takes operands from the forwarded ALU source muxes, and reports `busy` so hazard logic can stall HI/LO readers and new mul/div issue. It also supports software writes (MTHI/MTLO) and abort on pipeline flush.

## Interface

- `WIDTH`, 32, operand width; HI and LO are each WIDTH bits; must be ≥ 4 and even.
- `CNT_W`, $clog2(WIDTH)+1, iteration-counter width (derived; do not override).

- `clk` in 1: single clock; all state changes on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `start` in 1: launch the operation in `op` with `a`, `b`; accepted only in IDLE.
- `op` in 2: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
- `a` in WIDTH: multiplicand / dividend (rs).
- `b` in WIDTH: multiplier / divisor (rt).
- `mthi` in 1: write `wdata` to HI; accepted only in IDLE.
- `mtlo` in 1: write `wdata` to LO; accepted only in IDLE.
- `wdata` in WIDTH: MTHI/MTLO data.
- `flush` in 1: abort the in-flight operation.
- `busy` out 1: operation in progress; HI/LO are not valid.
- `done` out 1: one-cycle pulse in the cycle after HI/LO take the new result.
- `hi` out WIDTH: HI register (product upper half / remainder).
- `lo` out WIDTH: LO register (product lower half / quotient).

## Operation

- States: IDLE, RUN, FIX.
  - IDLE → RUN on `start & !flush`. Latch `op` and sign flags. Load the magnitudes |a| and |b| (unsigned ops use raw values). Clear the 2·WIDTH accumulator. Set the counter to WIDTH.
  - RUN does one iteration per cycle and decrements the counter. It goes to FIX when the counter reaches 0 after the iteration.
  - FIX applies the sign correction, writes HI/LO, asserts `done` for the following cycle, and goes to IDLE.
- Multiply uses radix-2 shift-add on magnitudes. The 2·WIDTH product P is negated if the op is signed and sign(a)≠sign(b). Then HI = P[2W-1:W] and LO = P[W-1:0].
- Divide uses restoring division on magnitudes, giving quotient Q and remainder R.
  - For signed ops, Q is negated if sign(a)≠sign(b), and R takes the sign of a.
  - LO = Q, HI = R.
- Divide by zero needs no special-casing; the algorithm yields:
  - DIVU: LO = all-ones, HI = a.
  - DIV: HI = a; LO = all-ones if a ≥ 0, else 1.
- DIV of most-negative by −1: LO = 100…0, HI = 0.
- All arithmetic is modulo 2^WIDTH per half; no overflow flag.
- `start` in RUN/FIX is ignored; the launching stage holds it until `busy` is low.
- `mthi`/`mtlo` in IDLE without `start`: HI/LO ← `wdata` at the edge. Both may be asserted together.
- In RUN/FIX, `mthi`/`mtlo` are ignored.
- `start` and `mthi`/`mtlo` in the same IDLE cycle: `start` wins and the writes are dropped.
- `flush` in RUN or FIX: go to IDLE at the edge, HI/LO unchanged, no `done`.
- `flush` with `start` in IDLE: `start` is ignored.
- `busy` = (state ≠ IDLE), decoded combinationally from state.

## Timing

- Reset (`rst_n` low at an edge): state IDLE, HI = 0, LO = 0, `busy` = 0, `done` = 0, counter = 0. This holds mid-operation too; the result is discarded.
- Start accepted at edge E0. `busy` = 1 from E0 through edge E0+WIDTH+1.
- RUN iterations occur at edges E0+1 … E0+WIDTH.
- FIX occurs at edge E0+WIDTH+1: HI/LO update there, state returns to IDLE, `busy` = 0 and `done` = 1 for exactly one cycle after that edge.
- Latency from start edge to valid HI/LO is WIDTH+1 cycles (33 for WIDTH=32).
- A back-to-back `start` is accepted at edge E0+WIDTH+2, in the cycle `done` is high.
- MTHI/MTLO latency: 1 edge. `done` is not asserted for writes.

## Test plan

- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → 33 cycles later HI=0xFFFFFFFE, LO=0x00000001. `done` high exactly 1 cycle; `busy` high for 33 cycles.
- MULT a=−3 (0xFFFFFFFD), b=5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1. MULT 0x80000000×0x80000000 → HI=0x40000000, LO=0.
- DIV −7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7/0 → LO=0xFFFFFFFF, HI=7. DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- Load HI=0x11, LO=0x22 via MTHI/MTLO. Start MULTU 6×7, then pulse `flush` at the 10th RUN cycle → `busy` low next cycle, HI=0x11, LO=0x22, no `done`. A `start` pulsed during RUN is ignored.
- Drive `rst_n` low at RUN cycle 5 → next edge HI=0, LO=0, `busy`=0, state IDLE. A new MULTU 2×3 then completes with LO=6.
- In IDLE, `mthi`=1 and `start`(MULTU 4×4) in the same cycle → HI unchanged at that edge. Final HI=0, LO=16. `mthi` asserted during RUN has no effect.
